// File: rtl/linescanner_line_packer_pkg.sv
// Shared types and constants for the line packer and its output word FIFO.
package linescanner_line_packer_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    localparam logic [BYTES_PER_WORD-1:0] KEEP_1B   = 4'h1;
    localparam logic [BYTES_PER_WORD-1:0] KEEP_2B   = 4'h3;
    localparam logic [BYTES_PER_WORD-1:0] KEEP_3B   = 4'h7;
    localparam logic [BYTES_PER_WORD-1:0] KEEP_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DISCARD = 2'd2
    } line_state_t;

    // keep is always a low-aligned run of ones, so bit 0 is implied by a valid entry
    typedef struct packed {
        logic                        last;
        logic [BYTES_PER_WORD-1:1]   keep_hi;
        logic [WORD_W-1:0]           data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic [BYTES_PER_WORD-1:0] keep_for_bytes(input logic [1:0] n);
        logic [BYTES_PER_WORD-1:0] keep;
        case (n)
            2'd1:    keep = KEEP_1B;
            2'd2:    keep = KEEP_2B;
            2'd3:    keep = KEEP_3B;
            default: keep = KEEP_FULL;
        endcase
        return keep;
    endfunction

    function automatic logic [WORD_W-1:0] keep_to_mask(input logic [BYTES_PER_WORD-1:0] keep);
        logic [WORD_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            mask[b*BYTE_W +: BYTE_W] = {BYTE_W{keep[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/linescanner_word_fifo.sv
// First-word-fall-through FIFO of packed output words; the head entry reads as zero when empty.
module linescanner_word_fifo
    import linescanner_line_packer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     pixel_clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_entry,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_entry = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/linescanner_line_packer.sv
// Packs captured pixel bytes into 32-bit words, one line per pixel_captured run,
// and queues them with byte-keep and end-of-line markers for a valid/ready consumer.
module linescanner_line_packer
    import linescanner_line_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LINE_CNT_W = 16
) (
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [BYTE_W-1:0]       pixel_data,
    input  logic                    pixel_captured,
    output logic [WORD_W-1:0]       m_data,
    output logic [BYTES_PER_WORD-1:0] m_keep,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LINE_CNT_W-1:0]   line_count,
    output logic                    overflow,
    input  logic                    clear_overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    line_state_t state, state_next;

    logic [1:0]                byte_idx, byte_idx_next;
    logic [WORD_W-1:0]         asm_reg, asm_next;
    logic                      pend_valid, pend_valid_next;
    logic [WORD_W-1:0]         pend_data, pend_data_next;
    logic                      flush_valid, flush_valid_next;
    logic [WORD_W-1:0]         flush_data, flush_data_next;
    logic [BYTES_PER_WORD-1:1] flush_keep_hi, flush_keep_hi_next;
    logic                      line_armed;

    logic                      push_req;
    logic                      push_ok;
    logic [WORD_W-1:0]         push_data;
    logic [BYTES_PER_WORD-1:1] push_keep_hi;
    logic                      push_last;
    logic [BYTES_PER_WORD-1:0] partial_keep;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    fifo_entry_t               push_entry;
    fifo_entry_t               head_entry;

    assign m_valid  = !fifo_empty;
    assign fifo_pop = m_valid && m_ready;
    assign push_ok  = !fifo_full || fifo_pop;
    assign fifo_push = push_req && push_ok;

    assign push_entry = '{last: push_last, keep_hi: push_keep_hi, data: push_data};

    linescanner_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_word_fifo (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .push        (fifo_push),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .pop_entry   (head_entry),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    assign m_data = head_entry.data;
    assign m_keep = {head_entry.keep_hi, m_valid};
    assign m_last = head_entry.last;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            byte_idx      <= '0;
            asm_reg       <= '0;
            pend_valid    <= 1'b0;
            pend_data     <= '0;
            flush_valid   <= 1'b0;
            flush_data    <= '0;
            flush_keep_hi <= '0;
        end else begin
            state         <= state_next;
            byte_idx      <= byte_idx_next;
            asm_reg       <= asm_next;
            pend_valid    <= pend_valid_next;
            pend_data     <= pend_data_next;
            flush_valid   <= flush_valid_next;
            flush_data    <= flush_data_next;
            flush_keep_hi <= flush_keep_hi_next;
        end
    end

    // A line already running when reset releases must be skipped, so a gap is required first.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            line_armed <= 1'b0;
        end else if (!pixel_captured) begin
            line_armed <= 1'b1;
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            line_count <= '0;
        end else begin
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
            if (fifo_push && push_last) begin
                line_count <= line_count + 1'b1;
            end
        end
    end

    // A partial tail word is latched at line end and pushed on the following cycle,
    // which never collides with a push from the next line's first word.
    always_comb begin
        state_next         = state;
        byte_idx_next      = byte_idx;
        asm_next           = asm_reg;
        pend_valid_next    = pend_valid;
        pend_data_next     = pend_data;
        flush_valid_next   = 1'b0;
        flush_data_next    = flush_data;
        flush_keep_hi_next = flush_keep_hi;
        push_req           = 1'b0;
        push_data          = '0;
        push_keep_hi       = '0;
        push_last          = 1'b0;
        partial_keep       = keep_for_bytes(byte_idx);

        if (flush_valid) begin
            push_req     = 1'b1;
            push_data    = flush_data;
            push_keep_hi = flush_keep_hi;
            push_last    = 1'b1;
        end

        case (state)
            IDLE: begin
                if (pixel_captured) begin
                    if (enable && line_armed) begin
                        state_next    = ACTIVE;
                        asm_next      = {{(WORD_W-BYTE_W){1'b0}}, pixel_data};
                        byte_idx_next = 2'd1;
                    end else begin
                        state_next = DISCARD;
                    end
                end
            end

            ACTIVE: begin
                if (pixel_captured) begin
                    asm_next[{byte_idx, 3'b000} +: BYTE_W] = pixel_data;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        pend_data_next  = asm_next;
                        pend_valid_next = 1'b1;
                        if (pend_valid) begin
                            push_req     = 1'b1;
                            push_data    = pend_data;
                            push_keep_hi = KEEP_FULL[BYTES_PER_WORD-1:1];
                            if (!push_ok) begin
                                state_next      = DISCARD;
                                pend_valid_next = 1'b0;
                                byte_idx_next   = '0;
                            end
                        end
                    end
                end else begin
                    state_next      = IDLE;
                    byte_idx_next   = '0;
                    pend_valid_next = 1'b0;
                    asm_next        = '0;
                    if (pend_valid) begin
                        push_req     = 1'b1;
                        push_data    = pend_data;
                        push_keep_hi = KEEP_FULL[BYTES_PER_WORD-1:1];
                        push_last    = (byte_idx == 2'd0);
                    end
                    if (byte_idx != 2'd0) begin
                        flush_valid_next   = !pend_valid || push_ok;
                        flush_data_next    = asm_reg & keep_to_mask(partial_keep);
                        flush_keep_hi_next = partial_keep[BYTES_PER_WORD-1:1];
                    end
                end
            end

            DISCARD: begin
                if (!pixel_captured) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    fifo_count_bound: assert property (
        @(posedge pixel_clock) disable iff (reset)
        fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH))
    );

endmodule

// File: tb/tb_linescanner_line_packer.sv
// Directed bench for linescanner_line_packer with a queued expected-word scoreboard.
module tb_linescanner_line_packer;

    localparam int FIFO_DEPTH = 8;
    localparam int LINE_CNT_W = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_word_t;

    logic                  pixel_clock = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [7:0]            pixel_data;
    logic                  pixel_captured;
    logic [31:0]           m_data;
    logic [3:0]            m_keep;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [LINE_CNT_W-1:0] line_count;
    logic                  overflow;
    logic                  clear_overflow;

    logic ready_level;
    logic ready_toggle;
    logic toggle_bit = 1'b0;

    int check_count = 0;
    int pass_count  = 0;

    exp_word_t exp_q[$];

    assign m_ready = ready_toggle ? toggle_bit : ready_level;

    linescanner_line_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LINE_CNT_W (LINE_CNT_W)
    ) dut (
        .pixel_clock    (pixel_clock),
        .reset          (reset),
        .enable         (enable),
        .pixel_data     (pixel_data),
        .pixel_captured (pixel_captured),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .line_count     (line_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 pixel_clock = ~pixel_clock;

    always begin
        @(posedge pixel_clock);
        #1;
        toggle_bit = ~toggle_bit;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Output words are compared against the queue head every cycle they are presented.
    always @(negedge pixel_clock) begin
        if (!reset && m_valid) begin
            check_count++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_word: got data=0x%08h keep=0x%0h last=%0b, expected no word",
                         m_data, m_keep, m_last);
            end else begin
                if ({m_data, m_keep, m_last} === {exp_q[0].data, exp_q[0].keep, exp_q[0].last}) begin
                    pass_count++;
                end else begin
                    $display("[TB] FAIL sb_word: got data=0x%08h keep=0x%0h last=%0b, expected data=0x%08h keep=0x%0h last=%0b",
                             m_data, m_keep, m_last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
                end
                if (m_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] data, input logic [3:0] keep, input logic last);
        exp_word_t e;
        e.data = data;
        e.keep = keep;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one line of n consecutive bytes followed by a single idle cycle.
    task automatic apply_stimulus(input int n, input logic [7:0] first,
                                  input logic en_first, input logic en_rest);
        for (int i = 0; i < n; i++) begin
            @(posedge pixel_clock);
            #1;
            pixel_captured = 1'b1;
            pixel_data     = first + 8'(i);
            enable         = (i == 0) ? en_first : en_rest;
        end
        @(posedge pixel_clock);
        #1;
        pixel_captured = 1'b0;
        pixel_data     = 8'h00;
    endtask

    task automatic wait_drain(input string name);
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 300) begin
            @(posedge pixel_clock);
            cycles++;
        end
        @(negedge pixel_clock);
        check_count++;
        if (exp_q.size() == 0) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d words outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic step();
        @(posedge pixel_clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        pixel_data     = 8'h00;
        pixel_captured = 1'b0;
        clear_overflow = 1'b0;
        ready_level    = 1'b1;
        ready_toggle   = 1'b0;

        #3;
        check_output("rst_m_valid",    32'(m_valid),    32'h0);
        check_output("rst_m_data",     m_data,          32'h0);
        check_output("rst_m_keep",     32'(m_keep),     32'h0);
        check_output("rst_m_last",     32'(m_last),     32'h0);
        check_output("rst_line_count", 32'(line_count), 32'h0);
        check_output("rst_overflow",   32'(overflow),   32'h0);
        step();
        step();
        reset = 1'b0;
        step();
        step();

        $display("[TB] eight-pixel line");
        push_exp(32'h04030201, 4'hF, 1'b0);
        push_exp(32'h08070605, 4'hF, 1'b1);
        apply_stimulus(8, 8'h01, 1'b1, 1'b1);
        @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_output("full_tail_latency", 32'({m_valid, m_last}), 32'h3);
        wait_drain("drain_eight");
        check_output("line_count_after_eight", 32'(line_count), 32'd1);

        $display("[TB] five-pixel line");
        push_exp(32'hA3A2A1A0, 4'hF, 1'b0);
        push_exp(32'h000000A4, 4'h1, 1'b1);
        apply_stimulus(5, 8'hA0, 1'b1, 1'b1);
        @(posedge pixel_clock);
        @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_output("partial_tail_latency", 32'({m_valid, m_last, m_keep}), 32'h31);
        wait_drain("drain_five");
        check_output("line_count_after_five", 32'(line_count), 32'd2);

        $display("[TB] short lines back to back");
        push_exp(32'h00131211, 4'h7, 1'b1);
        push_exp(32'h00000055, 4'h1, 1'b1);
        push_exp(32'h00006261, 4'h3, 1'b1);
        apply_stimulus(3, 8'h11, 1'b1, 1'b1);
        apply_stimulus(1, 8'h55, 1'b1, 1'b1);
        apply_stimulus(2, 8'h61, 1'b1, 1'b1);
        wait_drain("drain_short");
        check_output("line_count_after_short", 32'(line_count), 32'd5);

        $display("[TB] disabled line");
        apply_stimulus(12, 8'hC0, 1'b0, 1'b1);
        repeat (4) @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_output("disabled_no_word", 32'(m_valid), 32'h0);
        check_output("line_count_after_disabled", 32'(line_count), 32'd5);

        $display("[TB] stalled consumer");
        step();
        ready_toggle = 1'b1;
        push_exp(32'h23222120, 4'hF, 1'b0);
        push_exp(32'h27262524, 4'hF, 1'b0);
        push_exp(32'h2B2A2928, 4'hF, 1'b0);
        push_exp(32'h2F2E2D2C, 4'hF, 1'b1);
        apply_stimulus(16, 8'h20, 1'b1, 1'b1);
        wait_drain("drain_toggle");
        step();
        ready_toggle = 1'b0;
        check_output("line_count_after_toggle", 32'(line_count), 32'd6);

        $display("[TB] overflow line");
        ready_level = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] d;
            for (int b = 0; b < 4; b++) begin
                d[8*b +: 8] = 8'h40 + 8'(4*k + b);
            end
            push_exp(d, 4'hF, 1'b0);
        end
        apply_stimulus(40, 8'h40, 1'b1, 1'b1);
        repeat (3) @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_output("overflow_set", 32'(overflow), 32'h1);
        check_output("overflow_words_held", 32'(m_valid), 32'h1);
        check_output("line_count_after_overflow", 32'(line_count), 32'd6);
        step();
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        @(negedge pixel_clock);
        check_output("overflow_cleared", 32'(overflow), 32'h0);
        step();
        ready_level = 1'b1;
        wait_drain("drain_overflow");
        check_output("line_count_after_drain", 32'(line_count), 32'd6);

        $display("[TB] reset mid-line");
        step();
        ready_level = 1'b0;
        push_exp(32'h73727170, 4'hF, 1'b1);
        apply_stimulus(4, 8'h70, 1'b1, 1'b1);
        repeat (3) @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_output("pre_reset_valid", 32'(m_valid), 32'h1);
        check_output("pre_reset_line_count", 32'(line_count), 32'd7);
        for (int i = 0; i < 6; i++) begin
            step();
            pixel_captured = 1'b1;
            enable         = 1'b1;
            pixel_data     = 8'h90 + 8'(i);
        end
        step();
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_output("mid_reset_m_valid", 32'(m_valid), 32'h0);
        check_output("mid_reset_m_data", m_data, 32'h0);
        check_output("mid_reset_line_count", 32'(line_count), 32'h0);
        step();
        reset       = 1'b0;
        ready_level = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            pixel_data = 8'h96 + 8'(i);
        end
        step();
        pixel_captured = 1'b0;
        repeat (3) @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_output("post_reset_discard", 32'(m_valid), 32'h0);
        push_exp(32'h83828180, 4'hF, 1'b0);
        push_exp(32'h87868584, 4'hF, 1'b1);
        apply_stimulus(8, 8'h80, 1'b1, 1'b1);
        wait_drain("drain_after_reset");
        check_output("line_count_after_reset", 32'(line_count), 32'd1);

        repeat (4) @(posedge pixel_clock);
        @(negedge pixel_clock);
        check_output("final_idle", 32'(m_valid), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/linescanner_line_packer.md
LINESCANNER_LINE_PACKER -- requirements
Module: linescanner_line_packer

Interface
REQ-001 SHALL expose parameter FIFO_DEPTH, default 8 (power of two): output word FIFO depth in 32-bit words.
REQ-002 SHALL expose parameter LINE_CNT_W, default 16: width of the line counter.
REQ-003 pixel_clock  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 enable  in  1  line acceptance gate, sampled on the first pixel of a line.
REQ-006 pixel_data  in  8  pixel byte from the capture unit.
REQ-007 pixel_captured  in  1  high = pixel_data valid this cycle; high run = one line.
REQ-008 m_data  out  32  packed word; first pixel of a word in [7:0], fourth pixel in [31:24].
REQ-009 m_keep  out  4  byte-valid mask for m_data.
REQ-010 m_last  out  1  marks the final word of a line.
REQ-011 m_valid  out  1  word available.
REQ-012 m_ready  in  1  consumer accepts; transfer = m_valid & m_ready.
REQ-013 line_count  out  LINE_CNT_W  completed accepted lines, wraps modulo 2^LINE_CNT_W.
REQ-014 overflow  out  1  sticky; a word was dropped.
REQ-015 clear_overflow  in  1  synchronous clear of overflow.

Function
REQ-016 SHALL run an FSM with states IDLE, ACTIVE, DISCARD.
REQ-017 IDLE->ACTIVE when pixel_captured=1 and enable=1; that byte becomes byte 0 of the line.
REQ-018 IDLE->DISCARD when pixel_captured=1 and enable=0.
REQ-019 ACTIVE or DISCARD->IDLE on the first cycle with pixel_captured=0 (line end); enable changes mid-line are ignored.
REQ-020 In ACTIVE, each pixel_captured=1 cycle SHALL append the byte to an assembly register at byte index 0..3, index wrapping 3->0.
REQ-021 A completed 4-byte word SHALL move to a one-word pending register; a pending word is pushed to the FIFO with m_last=0 when the next word completes.
REQ-022 At line end the pending word SHALL be pushed with m_last=1, m_keep=4'hF when the byte index is 0; otherwise the pending word (if any) is pushed with m_last=0 in that cycle, and the partial word is pushed next cycle with m_last=1, unused bytes zero, m_keep=4'h1/4'h3/4'h7 for 1/2/3 bytes.
REQ-023 A line of 1..3 pixels SHALL yield exactly one word, m_last=1.
REQ-024 A push SHALL be accepted when FIFO occupancy < FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-025 A refused push SHALL drop the word, set overflow, and move ACTIVE->DISCARD for the rest of the line; no m_last is emitted for that line.
REQ-026 line_count SHALL increment by 1 in the cycle the m_last word is pushed; it does not increment for discarded or overflowed lines.
REQ-027 FIFO SHALL be first-word-fall-through: m_valid = not empty; m_data/m_keep/m_last stable while m_valid=1 and m_ready=0.
REQ-028 Latency: the last word of a line SHALL appear on m_valid no later than 2 cycles after line end when the FIFO is empty.
REQ-029 overflow set and clear_overflow in the same cycle: set wins.
REQ-030 Line end and a new line start cannot share a cycle; a one-cycle pixel_captured=0 gap SHALL suffice between lines.

Reset
REQ-031 reset=1 SHALL force: state IDLE, FIFO empty, m_valid=0, m_data=0, m_keep=0, m_last=0, line_count=0, overflow=0, byte index 0, pending register empty.
REQ-032 reset asserted mid-line SHALL discard all partial and queued data; after release, a line already in progress (pixel_captured=1) is treated as DISCARD until its end.

Structure
REQ-033 Shared package SHALL hold the FSM state type, the byte-width and word-width constants and the m_keep encodings.
REQ-034 FIFO SHALL be a sub-module linescanner_word_fifo (36-bit entries: data, keep, last), with push/pop/full/empty/count.

Verification
REQ-035 8 pixels 0x01..0x08, enable=1, m_ready=1 -> words 0x04030201 keep F last 0, 0x08070605 keep F last 1; line_count=1.
REQ-036 5 pixels 0xA0..0xA4 -> 0xA3A2A1A0 last 0, then 0x000000A4 keep 1 last 1.
REQ-037 enable=0 at line start, 12 pixels -> no words, line_count unchanged; enable raised mid-line has no effect.
REQ-038 m_ready=0, 40-pixel line -> 8 words queued, ninth dropped, overflow=1, no m_last; clear_overflow -> overflow=0.
REQ-039 m_ready toggling 1010 over a 16-pixel line -> 4 words in order, data stable while stalled, last on word 4.
REQ-040 reset pulse after 6 pixels of a line -> m_valid=0 immediately, remainder of line discarded, next line packs from byte 0.
